ccu_operation_fsm: RTL and testbench

CCU_OPERATION_FSM -- requirements
Module: ccu_operation_fsm

---
 rtl/ccu_operation_fsm_pkg.sv | 40 ++++
 rtl/ccu_operation_fsm_ccu_timer.sv | 33 +++
 rtl/ccu_operation_fsm.sv | 192 +++++++++++++++++++
 tb/tb_ccu_operation_fsm.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ccu_operation_fsm_pkg.sv
// Shared control-register definitions for the CCU operation sequencer:
// state encoding, status-bit positions, counter width and register offsets.
package ccu_operation_fsm_pkg;

  localparam int CCU_CNT_WIDTH = 32;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_STR       = 3'd1,
    ST_WAIT_LD   = 3'd2,
    ST_ISSUE     = 3'd3,
    ST_WAIT_ITER = 3'd4,
    ST_WAIT_TX   = 3'd5,
    ST_DONE      = 3'd6,
    ST_ERR       = 3'd7
  } ccu_state_e;

  // Bit positions inside the status register.
  localparam int STS_IDLE_BIT   = 0;
  localparam int STS_BUSY_BIT   = 1;
  localparam int STS_ERROR_BIT  = 2;
  localparam int STS_LOCKED_BIT = 3;
  localparam int STS_VALID_BIT  = 4;
  localparam int STS_WIDTH      = 5;

  localparam logic [7:0] REG_CTRL_OFS          = 8'h00;
  localparam logic [7:0] REG_STATUS_OFS        = 8'h04;
  localparam logic [7:0] REG_RSLT_SIZE_OFS     = 8'h08;
  localparam logic [7:0] REG_PCKT_SIZE_OFS     = 8'h0C;
  localparam logic [7:0] REG_PROGRESS_RSLT_OFS = 8'h10;
  localparam logic [7:0] REG_PROGRESS_ITER_OFS = 8'h14;
  localparam logic [7:0] REG_ITER_LATENCY_OFS  = 8'h18;
  localparam logic [7:0] REG_OPER_LATENCY_OFS  = 8'h1C;

  function automatic logic is_busy(input ccu_state_e s);
    return (s == ST_STR) || (s == ST_WAIT_LD) || (s == ST_ISSUE) ||
           (s == ST_WAIT_ITER) || (s == ST_WAIT_TX);
  endfunction

endpackage

// File: rtl/ccu_operation_fsm_ccu_timer.sv
// Saturating cycle counter with synchronous clear (priority) and enable.
module ccu_timer #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && !(&cnt_q)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/ccu_operation_fsm.sv
// CCU operation sequencer: start/load handshake, iteration issue loop,
// packet progress tracking, timing statistics and register-file strobes.
module ccu_operation_fsm
  import ccu_operation_fsm_pkg::*;
#(
  parameter int CNT_WIDTH = CCU_CNT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 operation_start,
  input  logic                 data_loaded,
  input  logic                 grid_loaded,
  input  logic                 scle_loaded,
  input  logic                 wght_loaded,
  input  logic [CNT_WIDTH-1:0] rslt_size,
  input  logic [CNT_WIDTH-1:0] pckt_size,
  input  logic                 interrupt_abort,
  input  logic                 interrupt_error,
  output logic                 iter_start,
  input  logic                 iter_done,
  input  logic                 tlast_sent,
  output logic                 sts_idle,
  output logic                 sts_busy,
  output logic                 sts_error,
  output logic                 sts_locked,
  output logic                 sts_valid,
  output logic [CNT_WIDTH-1:0] progress_rslt,
  output logic [CNT_WIDTH-1:0] progress_iter,
  output logic [CNT_WIDTH-1:0] iter_timer,
  output logic [CNT_WIDTH-1:0] iter_latency,
  output logic [CNT_WIDTH-1:0] oper_timer,
  output logic [CNT_WIDTH-1:0] oper_latency,
  output logic                 wo_reg_en,
  output logic                 wo_reg_rst,
  output logic                 pl2ps_reg_en,
  output logic                 rslt_loaded,
  output logic                 operation_done,
  output logic [2:0]           dbg_state
);

  localparam logic [STS_WIDTH-1:0] STS_RESET = STS_WIDTH'(1) << STS_IDLE_BIT;

  ccu_state_e           state_q, state_d;
  logic                 start_prev_q;
  logic [STS_WIDTH-1:0] sts_q, sts_d;
  logic [CNT_WIDTH-1:0] progress_rslt_q, progress_rslt_d;
  logic [CNT_WIDTH-1:0] progress_iter_q, progress_iter_d;
  logic [CNT_WIDTH-1:0] iter_latency_q, iter_latency_d;
  logic [CNT_WIDTH-1:0] oper_latency_q, oper_latency_d;
  logic                 rslt_loaded_q, rslt_loaded_d;
  logic                 operation_done_q, operation_done_d;

  logic                 all_loaded, start_rise, iter_accept, tx_accept, intr;
  logic                 iter_clr, iter_en, oper_clr, oper_en;
  logic [CNT_WIDTH:0]   rslt_sum;
  logic [CNT_WIDTH-1:0] rslt_next;
  logic [CNT_WIDTH-1:0] iter_timer_w, oper_timer_w;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + CNT_WIDTH'(1);
  endfunction

  // Progress is clamped so an oversized last packet never overshoots the total.
  assign rslt_sum  = {1'b0, progress_rslt_q} + {1'b0, pckt_size};
  assign rslt_next = (rslt_sum > {1'b0, rslt_size}) ? rslt_size : rslt_sum[CNT_WIDTH-1:0];

  always_comb begin
    all_loaded  = data_loaded & grid_loaded & scle_loaded & wght_loaded;
    start_rise  = operation_start & ~start_prev_q;
    intr        = interrupt_abort | interrupt_error;
    iter_accept = 1'b0;
    tx_accept   = 1'b0;
    state_d     = state_q;
    if (interrupt_abort) begin
      state_d = ST_IDLE;
    end else if (interrupt_error) begin
      state_d = ST_ERR;
    end else begin
      case (state_q)
        ST_IDLE:      if (start_rise) state_d = ST_STR;
        ST_STR:       state_d = (rslt_size == '0 || pckt_size == '0) ? ST_ERR : ST_WAIT_LD;
        ST_WAIT_LD:   if (all_loaded) state_d = ST_ISSUE;
        ST_ISSUE:     state_d = ST_WAIT_ITER;
        ST_WAIT_ITER: if (iter_done) begin
                        iter_accept = 1'b1;
                        state_d     = ST_WAIT_TX;
                      end
        ST_WAIT_TX:   if (tlast_sent) begin
                        tx_accept = 1'b1;
                        state_d   = (rslt_next == rslt_size) ? ST_DONE : ST_ISSUE;
                      end
        ST_DONE:      state_d = ST_IDLE;
        ST_ERR:       state_d = ST_ERR;
        default:      state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    progress_rslt_d  = progress_rslt_q;
    progress_iter_d  = progress_iter_q;
    iter_latency_d   = iter_latency_q;
    oper_latency_d   = oper_latency_q;
    rslt_loaded_d    = rslt_loaded_q;
    operation_done_d = operation_done_q;
    if (state_d == ST_STR) begin
      progress_rslt_d  = '0;
      progress_iter_d  = '0;
      iter_latency_d   = '0;
      oper_latency_d   = '0;
      rslt_loaded_d    = 1'b0;
      operation_done_d = 1'b0;
    end else begin
      if (iter_accept) begin
        iter_latency_d  = sat_inc(iter_timer_w);
        progress_iter_d = sat_inc(progress_iter_q);
      end
      if (tx_accept) progress_rslt_d = rslt_next;
      if (state_d == ST_DONE) begin
        oper_latency_d   = sat_inc(oper_timer_w);
        rslt_loaded_d    = 1'b1;
        operation_done_d = 1'b1;
      end
    end
    // Status mirrors the state being entered so it lines up with state_q.
    sts_d                 = '0;
    sts_d[STS_IDLE_BIT]   = (state_d == ST_IDLE);
    sts_d[STS_BUSY_BIT]   = is_busy(state_d);
    sts_d[STS_ERROR_BIT]  = (state_d == ST_ERR);
    sts_d[STS_LOCKED_BIT] = (state_d == ST_WAIT_LD) && !all_loaded;
    sts_d[STS_VALID_BIT]  = (state_d == ST_DONE) || (sts_q[STS_VALID_BIT] && state_d != ST_STR);
  end

  always_comb begin
    iter_clr = (state_d == ST_STR) || (state_d == ST_ISSUE);
    iter_en  = (state_q == ST_WAIT_ITER) && !intr;
    oper_clr = (state_d == ST_STR);
    oper_en  = is_busy(state_q) && (state_q != ST_STR) && !intr;
  end

  ccu_timer #(.W(CNT_WIDTH)) u_iter_timer (
    .clk (clk), .rst (rst), .clr (iter_clr), .en (iter_en), .cnt (iter_timer_w)
  );

  ccu_timer #(.W(CNT_WIDTH)) u_oper_timer (
    .clk (clk), .rst (rst), .clr (oper_clr), .en (oper_en), .cnt (oper_timer_w)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q          <= ST_IDLE;
      start_prev_q     <= 1'b0;
      sts_q            <= STS_RESET;
      progress_rslt_q  <= '0;
      progress_iter_q  <= '0;
      iter_latency_q   <= '0;
      oper_latency_q   <= '0;
      rslt_loaded_q    <= 1'b0;
      operation_done_q <= 1'b0;
    end else begin
      state_q          <= state_d;
      start_prev_q     <= operation_start;
      sts_q            <= sts_d;
      progress_rslt_q  <= progress_rslt_d;
      progress_iter_q  <= progress_iter_d;
      iter_latency_q   <= iter_latency_d;
      oper_latency_q   <= oper_latency_d;
      rslt_loaded_q    <= rslt_loaded_d;
      operation_done_q <= operation_done_d;
    end
  end

  assign iter_start     = (state_q == ST_ISSUE);
  assign wo_reg_rst     = (state_q == ST_STR);
  assign pl2ps_reg_en   = (state_q == ST_STR) || (state_q == ST_DONE);
  assign wo_reg_en      = tx_accept || (state_q == ST_DONE);
  assign sts_idle       = sts_q[STS_IDLE_BIT];
  assign sts_busy       = sts_q[STS_BUSY_BIT];
  assign sts_error      = sts_q[STS_ERROR_BIT];
  assign sts_locked     = sts_q[STS_LOCKED_BIT];
  assign sts_valid      = sts_q[STS_VALID_BIT];
  assign progress_rslt  = progress_rslt_q;
  assign progress_iter  = progress_iter_q;
  assign iter_timer     = iter_timer_w;
  assign iter_latency   = iter_latency_q;
  assign oper_timer     = oper_timer_w;
  assign oper_latency   = oper_latency_q;
  assign rslt_loaded    = rslt_loaded_q;
  assign operation_done = operation_done_q;
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_ccu_operation_fsm.sv
// Bench for ccu_operation_fsm: table of complete runs plus hand-written
// sequences for lock, configuration error, abort, held start and async reset.
module tb_ccu_operation_fsm;

  localparam int CW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          operation_start = 1'b0;
  logic          data_loaded = 1'b0, grid_loaded = 1'b0, scle_loaded = 1'b0, wght_loaded = 1'b0;
  logic [CW-1:0] rslt_size = '0, pckt_size = '0;
  logic          interrupt_abort = 1'b0, interrupt_error = 1'b0;
  logic          iter_done = 1'b0, tlast_sent = 1'b0;
  logic          iter_start;
  logic          sts_idle, sts_busy, sts_error, sts_locked, sts_valid;
  logic [CW-1:0] progress_rslt, progress_iter, iter_timer, iter_latency, oper_timer, oper_latency;
  logic          wo_reg_en, wo_reg_rst, pl2ps_reg_en, rslt_loaded, operation_done;
  logic [2:0]    dbg_state;

  int            n_cmp = 0;
  int            n_err = 0;
  logic [CW-1:0] exp_q[$];

  typedef struct {
    int unsigned rslt;
    int unsigned pckt;
    int          lat;
    int          iters;
  } vec_t;
  vec_t vecs[5];

  ccu_operation_fsm #(.CNT_WIDTH(CW)) dut (
    .clk (clk), .rst (rst), .operation_start (operation_start),
    .data_loaded (data_loaded), .grid_loaded (grid_loaded),
    .scle_loaded (scle_loaded), .wght_loaded (wght_loaded),
    .rslt_size (rslt_size), .pckt_size (pckt_size),
    .interrupt_abort (interrupt_abort), .interrupt_error (interrupt_error),
    .iter_start (iter_start), .iter_done (iter_done), .tlast_sent (tlast_sent),
    .sts_idle (sts_idle), .sts_busy (sts_busy), .sts_error (sts_error),
    .sts_locked (sts_locked), .sts_valid (sts_valid),
    .progress_rslt (progress_rslt), .progress_iter (progress_iter),
    .iter_timer (iter_timer), .iter_latency (iter_latency),
    .oper_timer (oper_timer), .oper_latency (oper_latency),
    .wo_reg_en (wo_reg_en), .wo_reg_rst (wo_reg_rst), .pl2ps_reg_en (pl2ps_reg_en),
    .rslt_loaded (rslt_loaded), .operation_done (operation_done),
    .dbg_state (dbg_state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Driver tasks
  task automatic wait_iter_start(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (iter_start) begin
        ok = 1'b1;
        return;
      end
      @(negedge clk);
    end
    n_cmp++;
    n_err++;
    $display("FAIL iter_start_timeout: got no pulse expected one within 60 cycles");
  endtask

  task automatic set_flags(input logic v);
    data_loaded = v; grid_loaded = v; scle_loaded = v; wght_loaded = v;
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 operation_start = 1'b1;
    @(posedge clk); #1 operation_start = 1'b0;
  endtask

  task automatic pulse_abort(input logic with_error);
    @(posedge clk); #1 interrupt_abort = 1'b1; interrupt_error = with_error;
    @(posedge clk); #1 interrupt_abort = 1'b0; interrupt_error = 1'b0;
  endtask

  // Full run; operation_start is left high so the caller decides when it drops.
  task automatic run_op(input int unsigned rs, input int unsigned ps, input int lat, input int iters);
    int unsigned   model_p;
    logic [CW-1:0] exp_v;
    bit            ok;
    rslt_size = rs;
    pckt_size = ps;
    set_flags(1'b1);
    @(posedge clk); #1 operation_start = 1'b1;
    model_p = 0;
    while (model_p < rs) begin
      wait_iter_start(ok);
      if (!ok) return;
      repeat (lat) @(posedge clk);
      #1 iter_done = 1'b1;
      @(posedge clk); #1 iter_done = 1'b0;
      @(posedge clk); #1 tlast_sent = 1'b1;
      model_p = (model_p + ps > rs) ? rs : model_p + ps;
      exp_q.push_back(model_p);
      @(negedge clk);
      check("wo_reg_en_on_tlast", wo_reg_en, 1);
      @(posedge clk); #1 tlast_sent = 1'b0;
      @(negedge clk);
      exp_v = exp_q.pop_front();
      check("progress_rslt", progress_rslt, exp_v);
    end
    check("done_operation_done", operation_done, 1);
    check("done_rslt_loaded", rslt_loaded, 1);
    check("done_sts_valid", sts_valid, 1);
    check("done_pl2ps_reg_en", pl2ps_reg_en, 1);
    check("done_wo_reg_en", wo_reg_en, 1);
    @(negedge clk);
    check("after_done_sts_idle", sts_idle, 1);
    check("progress_iter", progress_iter, iters);
    check("iter_latency", iter_latency, lat);
    check("oper_latency", oper_latency, 1 + iters * (lat + 3));
  endtask

  int  n_bad;
  bit  ok;

  initial begin
    vecs[0] = '{rslt: 10, pckt: 4,  lat: 5, iters: 3};
    vecs[1] = '{rslt: 8,  pckt: 4,  lat: 3, iters: 2};
    vecs[2] = '{rslt: 3,  pckt: 16, lat: 2, iters: 1};
    vecs[3] = '{rslt: 5,  pckt: 1,  lat: 1, iters: 5};
    vecs[4] = '{rslt: 7,  pckt: 7,  lat: 4, iters: 1};

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_sts_idle", sts_idle, 1);
    check("rst_sts_busy", sts_busy, 0);
    check("rst_sts_valid", sts_valid, 0);
    check("rst_progress_rslt", progress_rslt, 0);
    check("rst_oper_latency", oper_latency, 0);
    check("rst_iter_start", iter_start, 0);
    check("rst_pl2ps_reg_en", pl2ps_reg_en, 0);
    @(posedge clk); #1 rst = 1'b0;

    for (int v = 0; v < 5; v++) begin
      run_op(vecs[v].rslt, vecs[v].pckt, vecs[v].lat, vecs[v].iters);
      @(posedge clk); #1 operation_start = 1'b0;
    end

    // Locked: one operand missing holds the sequencer in WAIT_LD.
    rslt_size = 10; pckt_size = 4;
    set_flags(1'b1);
    wght_loaded = 1'b0;
    pulse_start();
    n_bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (iter_start) n_bad++;
    end
    check("locked_no_iter_start", n_bad, 0);
    check("locked_sts_locked", sts_locked, 1);
    check("locked_sts_busy", sts_busy, 1);
    @(posedge clk); #1 wght_loaded = 1'b1;
    @(negedge clk);
    check("unlock_iter_start_early", iter_start, 0);
    check("unlock_sts_locked_held", sts_locked, 1);
    @(negedge clk);
    check("unlock_iter_start", iter_start, 1);
    check("unlock_sts_locked_clear", sts_locked, 0);
    pulse_abort(1'b1);
    @(negedge clk);
    check("abort_over_error_idle", sts_idle, 1);
    check("abort_over_error_no_err", sts_error, 0);

    // Configuration error.
    pckt_size = 0;
    pulse_start();
    n_bad = 0;
    repeat (5) begin
      @(negedge clk);
      if (iter_start) n_bad++;
    end
    check("cfg_err_no_iter_start", n_bad, 0);
    check("cfg_err_sts_error", sts_error, 1);
    check("cfg_err_sts_busy", sts_busy, 0);
    pulse_abort(1'b0);
    @(negedge clk);
    check("cfg_err_abort_idle", sts_idle, 1);
    check("cfg_err_abort_error_clear", sts_error, 0);

    // Software error from IDLE is sticky until abort.
    @(posedge clk); #1 interrupt_error = 1'b1;
    @(posedge clk); #1 interrupt_error = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("intr_err_sticky", sts_error, 1);
    pulse_abort(1'b0);
    @(negedge clk);
    check("intr_err_abort_idle", sts_idle, 1);

    // Abort in WAIT_ITER with an in-flight iter_done, then stray pulses.
    pckt_size = 4;
    pulse_start();
    wait_iter_start(ok);
    @(posedge clk); #1 interrupt_abort = 1'b1; iter_done = 1'b1;
    @(posedge clk); #1 interrupt_abort = 1'b0;
    @(posedge clk); #1 iter_done = 1'b0; tlast_sent = 1'b1;
    @(negedge clk);
    check("stray_tlast_no_wo_reg_en", wo_reg_en, 0);
    @(posedge clk); #1 tlast_sent = 1'b0;
    @(negedge clk);
    check("abort_idle", sts_idle, 1);
    check("abort_progress_iter", progress_iter, 0);
    check("abort_progress_rslt", progress_rslt, 0);
    check("abort_iter_latency", iter_latency, 0);
    check("abort_operation_done", operation_done, 0);
    check("abort_sts_valid", sts_valid, 0);

    // Held start: no retrigger; a fresh edge clears everything in STR.
    run_op(10, 4, 5, 3);
    n_bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (iter_start || !sts_idle) n_bad++;
    end
    check("held_start_no_rerun", n_bad, 0);
    check("held_start_sts_valid", sts_valid, 1);
    @(posedge clk); #1 operation_start = 1'b0;
    @(posedge clk); #1 operation_start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("restart_wo_reg_rst", wo_reg_rst, 1);
    check("restart_pl2ps_reg_en", pl2ps_reg_en, 1);
    check("restart_progress_rslt", progress_rslt, 0);
    check("restart_progress_iter", progress_iter, 0);
    check("restart_oper_latency", oper_latency, 0);
    check("restart_sts_valid", sts_valid, 0);
    check("restart_operation_done", operation_done, 0);

    // Async reset between edges while in WAIT_TX.
    wait_iter_start(ok);
    repeat (3) @(posedge clk);
    #1 iter_done = 1'b1;
    @(posedge clk); #1 iter_done = 1'b0;
    @(negedge clk);
    check("pre_rst_progress_iter", progress_iter, 1);
    @(posedge clk); #3 rst = 1'b1; operation_start = 1'b0;
    #1;
    check("async_rst_state", dbg_state, 0);
    check("async_rst_sts_idle", sts_idle, 1);
    check("async_rst_sts_busy", sts_busy, 0);
    check("async_rst_progress_iter", progress_iter, 0);
    check("async_rst_iter_latency", iter_latency, 0);
    check("async_rst_oper_timer", oper_timer, 0);
    check("async_rst_iter_timer", iter_timer, 0);
    check("async_rst_wo_reg_en", wo_reg_en, 0);
    @(negedge clk); rst = 1'b0;
    repeat (2) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
